// File: rtl/pwd_pkg.sv
// Shared types for the DE2 password lock: result codes and
// control-FSM state encoding used by the checker, display and bench.
package pwd_pkg;

    localparam logic [1:0] RES_OK   = 2'b00;
    localparam logic [1:0] RES_BAD  = 2'b01;
    localparam logic [1:0] RES_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SET_OK  = 2'd1,
        ST_RESULT  = 2'd2,
        ST_BLOCKED = 2'd3
    } pwd_state_e;

endpackage

// File: rtl/key_edge_sync.sv
// Brings an asynchronous active-low key into the clock domain and
// emits a registered one-cycle strobe on each press.
module key_edge_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic strobe
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic strobe_q, strobe_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        strobe_d = prev_q & ~sync2_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/password_checker.sv
// Control stage of the password lock: stores/checks the code on ENTER,
// counts consecutive failures and enforces a timed lockout.
module password_checker
    import pwd_pkg::*;
#(
    parameter int                DATA_W      = 12,
    parameter logic [DATA_W-1:0] DEFAULT_PW  = '0,
    parameter int                MAX_TRIALS  = 3,
    parameter int                LOCK_CYCLES = 500_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              key_n,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    output logic [1:0]        result_out,
    output logic [1:0]        trials,
    output logic              block,
    output logic              set_done
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [1:0] TRIALS_LAST = 2'(MAX_TRIALS - 1);

    logic strobe;

    key_edge_sync u_key (
        .clock   (clock),
        .reset_n (reset_n),
        .key_n   (key_n),
        .strobe  (strobe)
    );

    pwd_state_e        state_q, state_d;
    logic [DATA_W-1:0] pw_q, pw_d;
    logic [1:0]        trials_q, trials_d;
    logic [1:0]        result_q, result_d;
    logic              block_q, block_d;
    logic              set_done_q, set_done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              mode_chg;
    logic              match;

    assign mode_chg = mode != mode_q;
    assign match    = data_in == pw_q;

    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        trials_d   = trials_q;
        result_d   = result_q;
        block_d    = block_q;
        set_done_d = 1'b0;
        cnt_d      = cnt_q;
        mode_d     = mode;
        case (state_q)
            ST_BLOCKED: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    block_d  = 1'b0;
                    result_d = RES_NONE;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // A mode flip discards any strobe arriving in the same cycle
                if (mode_chg) begin
                    result_d = RES_NONE;
                    state_d  = ST_IDLE;
                end else if (strobe) begin
                    unique case (1'b1)
                        !mode_q: begin
                            pw_d       = data_in;
                            set_done_d = 1'b1;
                            trials_d   = '0;
                            result_d   = RES_NONE;
                            state_d    = ST_SET_OK;
                        end
                        mode_q && match: begin
                            trials_d = '0;
                            result_d = RES_OK;
                            state_d  = ST_RESULT;
                        end
                        mode_q && !match && (trials_q != TRIALS_LAST): begin
                            trials_d = trials_q + 1'b1;
                            result_d = RES_BAD;
                            state_d  = ST_RESULT;
                        end
                        default: begin
                            trials_d = '0;
                            block_d  = 1'b1;
                            cnt_d    = '0;
                            result_d = RES_NONE;
                            state_d  = ST_BLOCKED;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            pw_q       <= DEFAULT_PW;
            trials_q   <= '0;
            result_q   <= RES_NONE;
            block_q    <= 1'b0;
            set_done_q <= 1'b0;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            trials_q   <= trials_d;
            result_q   <= result_d;
            block_q    <= block_d;
            set_done_q <= set_done_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
        end
    end

    assign result_out = result_q;
    assign trials     = trials_q;
    assign block      = block_q;
    assign set_done   = set_done_q;

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker: vector table plus hand-built
// lockout, mode-collision, long-hold and reset-during-lockout sequences.
module tb_password_checker;
    import pwd_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        key_n;
    logic        mode;
    logic [11:0] data_in;
    logic [1:0]  result_out;
    logic [1:0]  trials;
    logic        block;
    logic        set_done;

    int total = 0;
    int bad   = 0;

    password_checker #(
        .DATA_W      (12),
        .DEFAULT_PW  (12'h000),
        .MAX_TRIALS  (3),
        .LOCK_CYCLES (20)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key_n      (key_n),
        .mode       (mode),
        .data_in    (data_in),
        .result_out (result_out),
        .trials     (trials),
        .block      (block),
        .set_done   (set_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        m;
        logic [11:0] d;
        logic [1:0]  res;
        logic [1:0]  tr;
        logic        blk;
        logic        sd;
    } vec_t;

    vec_t vecs[9];

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    // Leaves the bench at the falling edge four cycles after the result edge
    task automatic press_check(input string nm, input logic m,
                               input logic [11:0] d, input logic [1:0] er,
                               input logic [1:0] et, input logic eb,
                               input logic es);
        if (mode !== m) begin
            mode = m;
            tick(2);
        end
        data_in = d;
        key_n   = 1'b0;
        tick(4);
        check({nm, ".res"}, 32'(result_out), 32'(er));
        check({nm, ".trials"}, 32'(trials), 32'(et));
        check({nm, ".block"}, 32'(block), 32'(eb));
        check({nm, ".set_done"}, 32'(set_done), 32'(es));
        tick(1);
        check({nm, ".set_done_end"}, 32'(set_done), 32'd0);
        key_n = 1'b1;
        tick(3);
    endtask

    initial begin
        vecs[0] = '{1'b1, 12'h000, RES_OK,   2'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 12'h123, RES_NONE, 2'd0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 12'h123, RES_OK,   2'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 12'h124, RES_BAD,  2'd1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 12'h999, RES_BAD,  2'd2, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 12'h123, RES_OK,   2'd0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 12'h000, RES_BAD,  2'd1, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 12'h555, RES_BAD,  2'd2, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 12'habc, RES_NONE, 2'd0, 1'b1, 1'b0};

        reset_n = 1'b0;
        key_n   = 1'b1;
        mode    = 1'b1;
        data_in = 12'h000;
        tick(2);
        check("rst.res", 32'(result_out), 32'(RES_NONE));
        check("rst.trials", 32'(trials), 32'd0);
        check("rst.block", 32'(block), 32'd0);
        check("rst.set_done", 32'(set_done), 32'd0);
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < 9; i++) begin
            press_check($sformatf("vec%0d", i), vecs[i].m, vecs[i].d,
                        vecs[i].res, vecs[i].tr, vecs[i].blk, vecs[i].sd);
        end

        // Locked at edge E; now at E+4. Press during lockout.
        data_in = 12'h123;
        key_n   = 1'b0;
        tick(4);
        check("lock.press.block", 32'(block), 32'd1);
        check("lock.press.res", 32'(result_out), 32'(RES_NONE));
        check("lock.press.trials", 32'(trials), 32'd0);
        tick(1);
        key_n = 1'b1;
        tick(3);
        tick(7);
        check("lock.e19.block", 32'(block), 32'd1);
        tick(1);
        check("lock.e20.block", 32'(block), 32'd0);
        check("lock.e20.res", 32'(result_out), 32'(RES_NONE));
        check("lock.e20.trials", 32'(trials), 32'd0);

        press_check("post_lock_bad", 1'b1, 12'h111, RES_BAD, 2'd1, 1'b0, 1'b0);

        // Mode flips in the same cycle the strobe is presented
        data_in = 12'h123;
        key_n   = 1'b0;
        tick(3);
        mode = 1'b0;
        tick(1);
        check("collide.res", 32'(result_out), 32'(RES_NONE));
        check("collide.trials", 32'(trials), 32'd1);
        check("collide.set_done", 32'(set_done), 32'd0);
        tick(1);
        key_n = 1'b1;
        tick(3);
        mode = 1'b1;
        tick(2);
        check("collide.after.trials", 32'(trials), 32'd1);

        // Long hold: one evaluation only
        data_in = 12'h777;
        key_n   = 1'b0;
        tick(100);
        check("hold.trials", 32'(trials), 32'd2);
        check("hold.res", 32'(result_out), 32'(RES_BAD));
        check("hold.block", 32'(block), 32'd0);
        key_n = 1'b1;
        tick(3);
        check("hold.rel.trials", 32'(trials), 32'd2);

        press_check("pw_kept", 1'b1, 12'h123, RES_OK, 2'd0, 1'b0, 1'b0);

        // Reset in the middle of a lockout
        press_check("r.bad1", 1'b1, 12'h888, RES_BAD, 2'd1, 1'b0, 1'b0);
        press_check("r.bad2", 1'b1, 12'h889, RES_BAD, 2'd2, 1'b0, 1'b0);
        press_check("r.lock", 1'b1, 12'h88a, RES_NONE, 2'd0, 1'b1, 1'b0);
        tick(6);
        check("r.pre.block", 32'(block), 32'd1);
        reset_n = 1'b0;
        #1;
        check("r.async.block", 32'(block), 32'd0);
        check("r.async.res", 32'(result_out), 32'(RES_NONE));
        check("r.async.trials", 32'(trials), 32'd0);
        tick(1);
        reset_n = 1'b1;
        tick(2);
        press_check("r.default_pw", 1'b1, 12'h123, RES_BAD, 2'd1, 1'b0, 1'b0);
        press_check("r.default_ok", 1'b1, 12'h000, RES_OK, 2'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
